// File: rtl/i2c_pkg.sv
// Shared I2C definitions: one-hot FSM state codes, bus level constants and address width.
package i2c_pkg;

    localparam int ADDR_W = 7;

    // Open-drain bus levels seen during the acknowledge clock
    localparam logic ACK_LVL  = 1'b0;
    localparam logic NACK_LVL = 1'b1;

    // One-hot state codes, 8 bits wide so the master can share the encoding
    localparam logic [7:0] ST_IDLE     = 8'h01;
    localparam logic [7:0] ST_ADDR     = 8'h02;
    localparam logic [7:0] ST_ADDR_ACK = 8'h04;
    localparam logic [7:0] ST_WR_DATA  = 8'h08;
    localparam logic [7:0] ST_WR_ACK   = 8'h10;
    localparam logic [7:0] ST_RD_DATA  = 8'h20;
    localparam logic [7:0] ST_RD_ACK   = 8'h40;

    typedef enum logic [7:0] {
        S_IDLE     = ST_IDLE,
        S_ADDR     = ST_ADDR,
        S_ADDR_ACK = ST_ADDR_ACK,
        S_WR_DATA  = ST_WR_DATA,
        S_WR_ACK   = ST_WR_ACK,
        S_RD_DATA  = ST_RD_DATA,
        S_RD_ACK   = ST_RD_ACK
    } state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizers with edge, START and STOP detection.
// Bit [0] is the metastability flop, [1] the synchronized level, [2] the history.
module i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_lvl,
    output logic scl_rise,
    output logic scl_fall,
    output logic bus_start,
    output logic bus_stop
);

    logic [2:0] scl_q, scl_d;
    logic [2:0] sda_q, sda_d;

    // Shift the raw pins through the synchronizer/history chain
    always_comb begin
        scl_d = {scl_q[1:0], scl_in};
        sda_d = {sda_q[1:0], sda_in};
    end

    // Idle bus is high, so the chain resets to 1 to avoid a false edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_q <= '1;
            sda_q <= '1;
        end else begin
            scl_q <= scl_d;
            sda_q <= sda_d;
        end
    end

    assign sda_lvl   = sda_q[1];
    assign scl_rise  = scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] & scl_q[2];
    assign bus_start = scl_q[1] & sda_q[2] & ~sda_q[1];
    assign bus_stop  = scl_q[1] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/i2c_slave.sv
// I2C target answering a fixed 7-bit address; no clock stretching, SDA is open-drain.
//
// state    | meaning
// IDLE     | not addressed; waiting for START
// ADDR     | shifting in address + R/W
// ADDR_ACK | driving ACK for a matched address
// WR_DATA  | shifting in a write byte
// WR_ACK   | driving ACK/NACK for a write byte
// RD_DATA  | shifting out a read byte
// RD_ACK   | sampling the master's ACK/NACK
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [ADDR_W-1:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_nack,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       addr_match,
    output logic       rw,
    output logic       busy,
    output logic       stop_det
);

    logic sda_lvl, scl_rise, scl_fall, bus_start, bus_stop;

    i2c_line_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl),
        .sda_in    (sda),
        .sda_lvl   (sda_lvl),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .bus_start (bus_start),
        .bus_stop  (bus_stop)
    );

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] cnt_q, cnt_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rw_q, rw_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       addr_match_q, addr_match_d;
    logic       tx_req_q, tx_req_d;
    logic       busy_q, busy_d;
    logic       stop_det_q, stop_det_d;
    logic [7:0] shift_in;

    // Next-state and output logic; START/STOP override any bit event
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        sda_oe_d     = sda_oe_q;
        rw_d         = rw_q;
        rx_data_d    = rx_data_q;
        busy_d       = busy_q;
        rx_valid_d   = 1'b0;
        addr_match_d = 1'b0;
        tx_req_d     = 1'b0;
        stop_det_d   = 1'b0;
        shift_in     = {shift_q[6:0], sda_lvl};

        if (bus_start) begin
            state_d  = S_ADDR;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b1;
        end else if (bus_stop) begin
            state_d    = S_IDLE;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            stop_det_d = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_ADDR: begin
                    if (scl_rise && cnt_q != 4'd8) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            if (shift_in[7:1] == SLAVE_ADDR) begin
                                rw_d         = shift_in[0];
                                addr_match_d = 1'b1;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        sda_oe_d = 1'b1;
                        tx_req_d = rw_q;
                        state_d  = S_ADDR_ACK;
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw_q) begin
                            shift_d  = tx_data;
                            sda_oe_d = ~tx_data[7];
                            cnt_d    = 4'd1;
                            state_d  = S_RD_DATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = 4'd0;
                            state_d  = S_WR_DATA;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (scl_rise && cnt_q != 4'd8) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            rx_data_d  = shift_in;
                            rx_valid_d = 1'b1;
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        sda_oe_d = ~rx_nack;
                        state_d  = S_WR_ACK;
                    end
                end
                S_WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = 4'd0;
                        state_d  = S_WR_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            cnt_d    = 4'd0;
                            state_d  = S_RD_ACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                            cnt_d    = cnt_q + 4'd1;
                        end
                    end
                end
                S_RD_ACK: begin
                    // cnt=1 marks an ACK seen, so the following fall reloads
                    if (scl_rise && cnt_q == 4'd0) begin
                        if (sda_lvl == ACK_LVL) begin
                            tx_req_d = 1'b1;
                            cnt_d    = 4'd1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else if (scl_fall && cnt_q == 4'd1) begin
                        shift_d  = tx_data;
                        sda_oe_d = ~tx_data[7];
                        cnt_d    = 4'd1;
                        state_d  = S_RD_DATA;
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers; reset releases SDA asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            sda_oe_q     <= 1'b0;
            rw_q         <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            addr_match_q <= 1'b0;
            tx_req_q     <= 1'b0;
            busy_q       <= 1'b0;
            stop_det_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            sda_oe_q     <= sda_oe_d;
            rw_q         <= rw_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            addr_match_q <= addr_match_d;
            tx_req_q     <= tx_req_d;
            busy_q       <= busy_d;
            stop_det_q   <= stop_det_d;
        end
    end

    assign sda        = sda_oe_q ? 1'b0 : 1'bz;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign tx_req     = tx_req_q;
    assign addr_match = addr_match_q;
    assign rw         = rw_q;
    assign busy       = busy_q;
    assign stop_det   = stop_det_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bit-banged master, pulse monitors, immediate-assert checks.
module tb_i2c_slave;
    import i2c_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       m_scl;
    logic       m_sda_low;
    logic       rx_nack;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid, tx_req, addr_match, rw, busy, stop_det;
    wire        sda;

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
        .clk        (clk),
        .reset      (reset),
        .scl        (m_scl),
        .sda        (sda),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_nack    (rx_nack),
        .tx_data    (tx_data),
        .tx_req     (tx_req),
        .addr_match (addr_match),
        .rw         (rw),
        .busy       (busy),
        .stop_det   (stop_det)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Pulse monitors
    int         rxv_cnt = 0, am_cnt = 0, txr_cnt = 0, sd_cnt = 0, slave_low_cnt = 0;
    logic [7:0] rx_log [64];

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log[rxv_cnt[5:0]] = rx_data;
            rxv_cnt++;
        end
        if (addr_match) am_cnt++;
        if (tx_req) txr_cnt++;
        if (stop_det) sd_cnt++;
        if (sda === 1'b0 && !m_sda_low) slave_low_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic quarter();
        repeat (10) @(negedge clk);
    endtask

    task automatic clk_bit(input logic b, output logic s);
        m_sda_low = ~b;
        quarter();
        m_scl = 1'b1;
        quarter();
        s = sda;
        quarter();
        m_scl = 1'b0;
        quarter();
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0;
        quarter();
        m_scl = 1'b1;
        quarter();
        m_sda_low = 1'b1;
        quarter();
        m_scl = 1'b0;
        quarter();
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1;
        quarter();
        m_scl = 1'b1;
        quarter();
        m_sda_low = 1'b0;
        quarter();
        quarter();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack_lvl);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, ack_lvl);
    endtask

    task automatic read_byte(input logic m_nack, input logic [7:0] next_tx, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            b[i] = s;
        end
        tx_data = next_tx;
        clk_bit(m_nack, s);
    endtask

    logic       ack;
    logic [7:0] rbyte;
    int         rxv0, am0, txr0, sd0, sl0;

    initial begin
        reset = 1'b0; m_scl = 1'b1; m_sda_low = 1'b0; rx_nack = 1'b0; tx_data = 8'h00;
        repeat (5) @(negedge clk);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_req", tx_req, 0);
        check("rst_addr_match", addr_match, 0);
        check("rst_rw", rw, 0);
        check("rst_busy", busy, 0);
        check("rst_stop_det", stop_det, 0);
        check("rst_sda", sda, 1);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Plain write of two bytes
        rxv0 = rxv_cnt; am0 = am_cnt; sd0 = sd_cnt;
        i2c_start();
        check("wr_busy_start", busy, 1);
        write_byte(8'hA0, ack); check("wr_addr_ack", ack, 0);
        check("wr_rw", rw, 0);
        write_byte(8'hA5, ack); check("wr_b0_ack", ack, 0);
        write_byte(8'h3C, ack); check("wr_b1_ack", ack, 0);
        i2c_stop();
        check("wr_rxv_cnt", rxv_cnt - rxv0, 2);
        check("wr_rx0", rx_log[rxv0], 8'hA5);
        check("wr_rx1", rx_log[rxv0 + 1], 8'h3C);
        check("wr_am_cnt", am_cnt - am0, 1);
        check("wr_stop_cnt", sd_cnt - sd0, 1);
        check("wr_busy_end", busy, 0);

        // Address mismatch
        rxv0 = rxv_cnt; am0 = am_cnt; txr0 = txr_cnt; sl0 = slave_low_cnt;
        i2c_start();
        write_byte(8'hA2, ack); check("mm_addr_nack", ack, 1);
        check("mm_busy", busy, 1);
        write_byte(8'h33, ack); check("mm_byte_nack", ack, 1);
        i2c_stop();
        check("mm_sda_never_low", slave_low_cnt - sl0, 0);
        check("mm_am_cnt", am_cnt - am0, 0);
        check("mm_rxv_cnt", rxv_cnt - rxv0, 0);
        check("mm_txr_cnt", txr_cnt - txr0, 0);

        // Read two bytes, ACK then NACK
        txr0 = txr_cnt;
        tx_data = 8'h96;
        i2c_start();
        write_byte(8'hA1, ack); check("rd_addr_ack", ack, 0);
        check("rd_rw", rw, 1);
        read_byte(1'b0, 8'h0F, rbyte); check("rd_byte0", rbyte, 8'h96);
        read_byte(1'b1, 8'h00, rbyte); check("rd_byte1", rbyte, 8'h0F);
        check("rd_idle_after_nack", dut.state_q, S_IDLE);
        check("rd_sda_released", sda, 1);
        check("rd_txr_cnt", txr_cnt - txr0, 2);
        i2c_stop();

        // Slave NACKs the second write byte
        rxv0 = rxv_cnt;
        i2c_start();
        write_byte(8'hA0, ack); check("nk_addr_ack", ack, 0);
        write_byte(8'h11, ack); check("nk_b0_ack", ack, 0);
        rx_nack = 1'b1;
        write_byte(8'h22, ack); check("nk_b1_nack", ack, 1);
        rx_nack = 1'b0;
        i2c_stop();
        check("nk_rxv_cnt", rxv_cnt - rxv0, 2);
        check("nk_rx1", rx_log[rxv0 + 1], 8'h22);

        // Repeated START: register write then read
        rxv0 = rxv_cnt; am0 = am_cnt;
        i2c_start();
        write_byte(8'hA0, ack); check("sr_wr_ack", ack, 0);
        check("sr_rw0", rw, 0);
        write_byte(8'h10, ack); check("sr_reg_ack", ack, 0);
        tx_data = 8'h55;
        i2c_start();
        write_byte(8'hA1, ack); check("sr_rd_ack", ack, 0);
        check("sr_rw1", rw, 1);
        read_byte(1'b1, 8'h00, rbyte); check("sr_byte", rbyte, 8'h55);
        i2c_stop();
        check("sr_am_cnt", am_cnt - am0, 2);
        check("sr_rx_reg", rx_log[rxv0], 8'h10);

        // Reset mid-read while the target holds SDA low
        tx_data = 8'h00;
        i2c_start();
        write_byte(8'hA1, ack); check("mr_addr_ack", ack, 0);
        check("mr_sda_driven", sda, 0);
        reset = 1'b0;
        #1;
        check("mr_sda_released", sda, 1);
        check("mr_rw", rw, 0);
        check("mr_busy", busy, 0);
        check("mr_rx_data", rx_data, 8'h00);
        check("mr_tx_req", tx_req, 0);
        @(negedge clk);
        reset = 1'b1;
        quarter();
        rxv0 = rxv_cnt; sd0 = sd_cnt;
        i2c_start();
        write_byte(8'hA0, ack); check("pr_addr_ack", ack, 0);
        write_byte(8'h5A, ack); check("pr_byte_ack", ack, 0);
        i2c_stop();
        check("pr_rxv_cnt", rxv_cnt - rxv0, 1);
        check("pr_rx", rx_log[rxv0], 8'h5A);
        check("pr_stop_cnt", sd_cnt - sd0, 1);
        check("pr_busy", busy, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
